// File: rtl/result_collector_if.sv
// -----------------------------------------------------------------------------
// result_collector_if
//
// Bundles the accumulator result write port, the clear pulse and the drain
// stream of result_collector into one interface.
//
//   write_data  : result write strobe, one row result per asserted cycle
//   addr_data   : row index of the write
//   data        : row result
//   clear       : one-cycle flush pulse (valid bits, counters, FSM)
//   out_valid   : drain stream data valid
//   out_ready   : drain stream consumer ready
//   out_row     : row index of out_data
//   out_data    : row result
//   out_last    : marks the final row beat
//   done        : set once the final beat has been accepted
//   err         : sticky protocol error flag
//
// Modports:
//   master : accumulator / host side (drives writes, clear and out_ready)
//   slave  : result_collector side
// -----------------------------------------------------------------------------
interface result_collector_if #(
  parameter int row_id_size      = 4,
  parameter int accumulator_size = 32
);

  logic                        write_data;
  logic [row_id_size-1:0]      addr_data;
  logic [accumulator_size-1:0] data;
  logic                        clear;

  logic                        out_valid;
  logic                        out_ready;
  logic [row_id_size-1:0]      out_row;
  logic [accumulator_size-1:0] out_data;
  logic                        out_last;
  logic                        done;
  logic                        err;

  modport master (
    output write_data, addr_data, data, clear, out_ready,
    input  out_valid, out_row, out_data, out_last, done, err
  );

  modport slave (
    input  write_data, addr_data, data, clear, out_ready,
    output out_valid, out_row, out_data, out_last, done, err
  );

endinterface

// File: rtl/result_collector.sv
// -----------------------------------------------------------------------------
// result_collector
//
// Last stage of the SpMV datapath. Captures the per-row dot products emitted
// by the CISR accumulator into a row-indexed buffer and, once every row
// 0..row_num-1 has been seen, streams them out in ascending row order over a
// valid/ready interface.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : result_collector_if.slave
//            write_data/addr_data/data : accumulator result write port
//            clear                     : flush pulse, returns to COLLECT
//            out_valid/out_ready/out_row/out_data/out_last : drain stream
//            done                      : high after the final beat is taken
//            err                       : sticky protocol error
//
// Parameters:
//   row_id_size      : width of the row address
//   accumulator_size : width of each result
//   row_num          : rows to collect (1 .. 2**row_id_size)
//
// Build option:
//   RESULT_ACCUMULATE_EN : when defined, a repeated write to an already
//   captured row is added to the stored value (partial sums of split rows)
//   instead of overwriting it and flagging an error.
// -----------------------------------------------------------------------------
module result_collector #(
  parameter int row_id_size      = 4,
  parameter int accumulator_size = 32,
  parameter int row_num          = 16
) (
  input logic              clk,
  input logic              rst,
  result_collector_if.slave bus
);

  localparam int depth = 1 << row_id_size;

  // Row counts need one extra bit so that row_num == 2**row_id_size fits.
  localparam logic [row_id_size:0] row_limit = (row_id_size + 1)'(row_num);
  localparam logic [row_id_size:0] last_row  = (row_id_size + 1)'(row_num - 1);
  localparam logic [row_id_size:0] one_cnt   = (row_id_size + 1)'(1);

`ifdef RESULT_ACCUMULATE_EN
  localparam bit accumulate_en = 1'b1;
`else
  localparam bit accumulate_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Result buffer. Contents are never reset; the valid bits say what is live.
  logic [accumulator_size-1:0] mem [depth];

  logic [depth-1:0]            valid_reg;
  logic [depth-1:0]            row_hit;
  logic [row_id_size:0]        rows_seen_reg;
  logic [row_id_size:0]        rd_ptr_reg;
  logic                        err_reg;

  logic                        out_valid_reg;
  logic [row_id_size-1:0]      out_row_reg;
  logic [accumulator_size-1:0] out_data_reg;
  logic                        out_last_reg;

  logic wr_in_range;
  logic wr_dup;
  logic wr_accept;
  logic wr_error;
  logic beat_accept;
  logic final_accept;
  logic load_beat;

  // ---------------------------------------------------------------------------
  // Write-side decode
  // ---------------------------------------------------------------------------

  // One-hot decode of the write address, used both to set the valid bit and
  // to look up whether the addressed row has already been captured.
  for (genvar gi = 0; gi < depth; gi++) begin : g_row_hit
    assign row_hit[gi] = (bus.addr_data == row_id_size'(gi));
  end

  assign wr_in_range = ({1'b0, bus.addr_data} < row_limit);
  assign wr_dup      = |(valid_reg & row_hit);

  // clear wins over a coincident write: the write is simply dropped.
  assign wr_accept = bus.write_data && !bus.clear &&
                     (state_reg == COLLECT) && wr_in_range;

  always_comb begin
    wr_error = 1'b0;
    if (bus.write_data && !bus.clear) begin
      if (state_reg != COLLECT) begin
        wr_error = 1'b1;
      end else if (!wr_in_range) begin
        wr_error = 1'b1;
      end else if (wr_dup && !accumulate_en) begin
        wr_error = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer write port. In accumulate builds a repeated row is a
  // read-modify-write of the stored value (wraps modulo 2**accumulator_size).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      if (accumulate_en && wr_dup) begin
        mem[bus.addr_data] <= mem[bus.addr_data] + bus.data;
      end else begin
        mem[bus.addr_data] <= bus.data;
      end
    end
  end

  // Valid bits and distinct-row counter. Only the first write to a row counts
  // towards completion, whatever the build option.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      valid_reg     <= '0;
      rows_seen_reg <= '0;
    end else if (wr_accept && !wr_dup) begin
      valid_reg     <= valid_reg | row_hit;
      rows_seen_reg <= rows_seen_reg + one_cnt;
    end
  end

  // Sticky error; survives clear, only rst removes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (wr_error) begin
      err_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain stream
  // ---------------------------------------------------------------------------
  assign beat_accept  = out_valid_reg && bus.out_ready;
  assign final_accept = beat_accept && out_last_reg;

  // The output register is refilled whenever it is empty or being emptied this
  // cycle. rd_ptr_reg always holds the address of the next row to present, so
  // the registered buffer read lands exactly when the current beat leaves and
  // back-to-back beats need no bubble.
  assign load_beat = (state_reg == DRAIN) &&
                     (!out_valid_reg || bus.out_ready) &&
                     !final_accept &&
                     (rd_ptr_reg < row_limit);

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      out_valid_reg <= 1'b0;
      out_row_reg   <= '0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      rd_ptr_reg    <= '0;
    end else if (final_accept) begin
      out_valid_reg <= 1'b0;
    end else if (load_beat) begin
      out_valid_reg <= 1'b1;
      out_row_reg   <= rd_ptr_reg[row_id_size-1:0];
      out_data_reg  <= mem[rd_ptr_reg[row_id_size-1:0]];
      out_last_reg  <= (rd_ptr_reg == last_row);
      rd_ptr_reg    <= rd_ptr_reg + one_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      // The write that completes the set is stored first; the counter is
      // seen full one cycle later, which is when draining starts.
      COLLECT: if (rows_seen_reg == row_limit) state_next = DRAIN;
      DRAIN:   if (final_accept)               state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = COLLECT;
    endcase
    if (bus.clear) begin
      state_next = COLLECT;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.out_valid = out_valid_reg;
  assign bus.out_row   = out_row_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.done      = (state_reg == DONE);
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_result_collector.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_result_collector
//
// Three collectors (row_num = 16, 12 and 1) share one set of stimulus signals;
// `sel` routes writes/clear to one of them and muxes its outputs back. A
// row-set reference model (which rows are captured, their values, whether
// collection is finished, sticky error) predicts every drained beat.
// -----------------------------------------------------------------------------
module tb_result_collector;

  localparam int RID = 4;
  localparam int ACC = 32;

`ifdef RESULT_ACCUMULATE_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr;
  logic        rdy;
  int          sel;

  always #5 clk = ~clk;

  result_collector_if #(.row_id_size(RID), .accumulator_size(ACC)) bus16 ();
  result_collector_if #(.row_id_size(RID), .accumulator_size(ACC)) bus12 ();
  result_collector_if #(.row_id_size(RID), .accumulator_size(ACC)) bus1 ();

  assign bus16.write_data = wr_en && (sel == 0);
  assign bus16.addr_data  = wr_addr;
  assign bus16.data       = wr_data;
  assign bus16.clear      = clr && (sel == 0);
  assign bus16.out_ready  = rdy;

  assign bus12.write_data = wr_en && (sel == 1);
  assign bus12.addr_data  = wr_addr;
  assign bus12.data       = wr_data;
  assign bus12.clear      = clr && (sel == 1);
  assign bus12.out_ready  = rdy;

  assign bus1.write_data  = wr_en && (sel == 2);
  assign bus1.addr_data   = wr_addr;
  assign bus1.data        = wr_data;
  assign bus1.clear       = clr && (sel == 2);
  assign bus1.out_ready   = rdy;

  result_collector #(.row_id_size(RID), .accumulator_size(ACC), .row_num(16)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16.slave));
  result_collector #(.row_id_size(RID), .accumulator_size(ACC), .row_num(12)) dut12 (
    .clk(clk), .rst(rst), .bus(bus12.slave));
  result_collector #(.row_id_size(RID), .accumulator_size(ACC), .row_num(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  logic        o_valid, o_last, o_done, o_err;
  logic [3:0]  o_row;
  logic [31:0] o_data;

  always_comb begin
    case (sel)
      1: {o_valid, o_row, o_data, o_last, o_done, o_err} =
           {bus12.out_valid, bus12.out_row, bus12.out_data, bus12.out_last, bus12.done, bus12.err};
      2: {o_valid, o_row, o_data, o_last, o_done, o_err} =
           {bus1.out_valid, bus1.out_row, bus1.out_data, bus1.out_last, bus1.done, bus1.err};
      default: {o_valid, o_row, o_data, o_last, o_done, o_err} =
           {bus16.out_valid, bus16.out_row, bus16.out_data, bus16.out_last, bus16.done, bus16.err};
    endcase
  end

  // ---------------- reference model ----------------
  int          rn;
  bit          collecting;
  bit          seen [16];
  logic [31:0] val [16];
  int          nseen;
  bit          err_m [3];
  int          drain_idx;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        exp_err;
  } vec_t;
  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    collecting = 1'b1;
    nseen      = 0;
    drain_idx  = 0;
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
  endtask

  task automatic select(input int s);
    sel = s;
    rn  = (s == 1) ? 12 : (s == 2) ? 1 : 16;
  endtask

  task automatic pulse_clear(input bit with_wr, input logic [3:0] a);
    @(negedge clk);
    clr = 1'b1; rdy = 1'b0;
    wr_en = with_wr; wr_addr = a; wr_data = 32'hDEAD_0000;
    @(posedge clk);
    #1 clr = 1'b0; wr_en = 1'b0;
    model_clear();
    $display("rows=%0d clear (write alongside=%0b)", rn, with_wr);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; clr = 1'b0; rdy = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) err_m[i] = 1'b0;
    model_clear();
    $display("rows=%0d reset", rn);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
    if (!collecting) begin
      err_m[sel] = 1'b1;
    end else if (int'(a) >= rn) begin
      err_m[sel] = 1'b1;
    end else if (seen[a]) begin
      if (ACC_EN) val[a] = val[a] + d;
      else begin
        val[a]     = d;
        err_m[sel] = 1'b1;
      end
    end else begin
      seen[a] = 1'b1;
      val[a]  = d;
      nseen++;
      if (nseen == rn) collecting = 1'b0;
    end
    $display("rows=%0d write row=%0d data=0x%0h", rn, a, d);
  endtask

  // Set complete at edge Ew: still COLLECT after Ew, DRAIN after Ew+1,
  // first beat valid after Ew+2.
  task automatic check_latency();
    rdy = 1'b0;
    @(negedge clk); check("lat_collect", o_valid, 0);
    @(negedge clk); check("lat_drain_entry", o_valid, 0);
    @(negedge clk); check("lat_first_beat", o_valid, 1);
  endtask

  // mode 0: ready always high, 1: toggling, 2: random.
  task automatic drain(input int max_beats, input int mode, output int span);
    int beats, cycles, first_c, last_c;
    bit held, finished;
    logic [36:0] held_v, exp_beat;
    logic [31:0] ev;
    beats = 0; cycles = 0; first_c = -1; last_c = 0;
    held = 1'b0; finished = 1'b0; held_v = '0;
    while (beats < max_beats && !finished && cycles < 2000) begin
      @(negedge clk);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (held) begin
        check("hold_stable", {o_valid, o_row, o_data, o_last}, {1'b1, held_v});
        held = 1'b0;
      end
      if (o_valid) begin
        if (rdy) begin
          ev       = (drain_idx < 16) ? val[drain_idx] : 32'h0;
          exp_beat = {4'(drain_idx), ev, (drain_idx == rn - 1)};
          check("beat", {o_row, o_data, o_last}, exp_beat);
          $display("rows=%0d beat row=%0d data=0x%0h last=%0b", rn, o_row, o_data, o_last);
          if (first_c < 0) first_c = cycles;
          last_c = cycles;
          beats++;
          drain_idx++;
          if (o_last) finished = 1'b1;
        end else begin
          held   = 1'b1;
          held_v = {o_row, o_data, o_last};
        end
      end
      cycles++;
    end
    if (!finished && beats < max_beats) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d beats, expected %0d", beats, max_beats);
    end
    span = last_c - first_c + 1;
  endtask

  task automatic check_done();
    @(negedge clk);
    check("done_state", {o_valid, o_done}, {1'b0, 1'b1});
    check("err_flag", o_err, err_m[sel]);
  endtask

  int perm [16];

  task automatic shuffle();
    int j, t;
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = rn - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int span;

    // Out-of-range table for the 12-row collector.
    for (int i = 0; i < 6; i++) tbl[i] = '{addr: 4'(i), data: 32'(200 + i), exp_err: 1'b0};
    tbl[6] = '{addr: 4'd12, data: 32'd999, exp_err: 1'b1};
    tbl[7] = '{addr: 4'd13, data: 32'd998, exp_err: 1'b1};
    for (int i = 6; i < 11; i++) tbl[i + 2] = '{addr: 4'(i), data: 32'(200 + i), exp_err: 1'b1};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0; rdy = 1'b0;
    select(0);
    for (int i = 0; i < 3; i++) err_m[i] = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values on all three collectors.
    for (int s = 0; s < 3; s++) begin
      select(s);
      #1;
      check("reset_outputs", {o_valid, o_row, o_data, o_last, o_done, o_err}, 64'h0);
    end

    // In-order rows, ready held high: latency, no bubbles, done.
    select(0);
    model_clear();
    for (int r = 0; r < 16; r++) wr(4'(r), 32'(r * 3));
    check_latency();
    drain(16, 0, span);
    check("throughput_span", span, 16);
    check_done();

    // Permuted order, toggling ready.
    pulse_clear(1'b0, 4'd0);
    begin
      int order [16];
      int k;
      order[0] = 15; order[1] = 3; order[2] = 0; k = 3;
      for (int r = 0; r < 16; r++) if (r != 15 && r != 3 && r != 0) begin order[k] = r; k++; end
      for (int i = 0; i < 16; i++) wr(4'(order[i]), 32'(100 + order[i]));
    end
    drain(16, 1, span);
    check_done();

    // Duplicate row 5: 10 then 7.
    pulse_clear(1'b0, 4'd0);
    wr(4'd5, 32'd10);
    wr(4'd5, 32'd7);
    for (int r = 0; r < 15; r++) if (r != 5) wr(4'(r), 32'(100 + r));
    repeat (3) @(negedge clk);
    check("dup_not_complete", o_valid, 0);
    wr(4'd15, 32'd115);
    check_latency();
    drain(16, 2, span);
    check_done();

    // clear after 6 drained beats, with a write alongside the clear.
    pulse_clear(1'b0, 4'd0);
    for (int r = 0; r < 16; r++) wr(4'(r), 32'(r * 7 + 1));
    drain(6, 0, span);
    pulse_clear(1'b1, 4'd0);
    @(negedge clk);
    check("clear_mid_drain", {o_valid, o_done}, 64'h0);
    check("clear_keeps_err", o_err, err_m[0]);
    for (int r = 0; r < 16; r++) wr(4'(r), 32'(r + 500));
    drain(16, 0, span);
    check_done();

    // rst after 8 rows of a fresh set.
    pulse_clear(1'b0, 4'd0);
    for (int r = 0; r < 8; r++) wr(4'(r), 32'(r + 40));
    pulse_rst();
    @(negedge clk);
    check("rst_outputs", {o_valid, o_row, o_data, o_last, o_done, o_err}, 64'h0);
    for (int r = 8; r < 16; r++) wr(4'(r), 32'(r + 60));
    repeat (3) @(negedge clk);
    check("rst_forgets_rows", o_valid, 0);
    for (int r = 0; r < 8; r++) wr(4'(r), 32'(r + 60));
    check_latency();
    drain(16, 0, span);
    check_done();

    // row_num=12: table of writes including out-of-range rows, then a write
    // during DRAIN that must not touch the buffer.
    select(1);
    pulse_clear(1'b0, 4'd0);
    for (int i = 0; i < 13; i++) begin
      wr(tbl[i].addr, tbl[i].data);
      check("tbl_err", o_err, tbl[i].exp_err);
    end
    repeat (3) @(negedge clk);
    check("oor_not_complete", o_valid, 0);
    wr(4'd11, 32'd211);
    check_latency();
    wr(4'd2, 32'hDEAD_BEEF);
    drain(12, 2, span);
    check_done();

    // row_num=1: single write, single last beat; write during DRAIN sets err.
    select(2);
    pulse_clear(1'b0, 4'd0);
    wr(4'd0, 32'h1234_5678);
    check_latency();
    wr(4'd0, 32'h0000_FFFF);
    @(negedge clk);
    check("drain_write_err", o_err, err_m[2]);
    drain(1, 0, span);
    check_done();

    // Randomised rounds across all three collectors.
    for (int round = 0; round < 9; round++) begin
      select(round % 3);
      pulse_clear(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      shuffle();
      for (int i = 0; i < rn; i++) begin
        if (!collecting) break;
        if ($urandom_range(0, 3) == 0) begin
          wr(4'($urandom_range(0, 15)), $urandom);
          if (!collecting) break;
        end
        wr(4'(perm[i]), $urandom);
      end
      drain(rn, 2, span);
      check_done();
    end

    // clear together with an out-of-range write must not raise err.
    pulse_rst();
    select(1);
    pulse_clear(1'b1, 4'd14);
    @(negedge clk);
    check("clear_drops_write", o_err, err_m[1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
